xspi_crc_retx_ctrl: RTL

Transmit-side frame controller for the xSPI 8S CRC-protected link. Buffers one outgoing payload frame (up to MAX_LEN bytes) and streams it to the PHY. Sequences a crc8 engine (POLY 0x07, init 0x00) over the payload, appends the CRC byte, then waits for a link ACK/NAK. On NAK or timeout it retransmits the buffered frame, up to MAX_RETRY times.

---
 rtl/xspi_crc_pkg.sv | 35 +++
 rtl/xspi_crc_retx_ctrl_if.sv | 26 ++
 rtl/crc8.sv | 28 ++
 rtl/xspi_crc_retx_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/xspi_crc_pkg.sv
// rtl/xspi_crc_pkg.sv - shared types and constants for the xSPI CRC retransmit controller
// Purpose: controller state encoding, crc8 constants, ACK/NAK encoding and the
//          bytewise crc8 update function used by the crc8 engine.
// Ports:   none (package).
package xspi_crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREP,
    ST_SEND,
    ST_SEND_CRC,
    ST_WAIT_ACK
  } state_t;

  localparam logic [7:0] CRC8_POLY            = 8'h07;
  localparam logic [7:0] CRC8_INIT            = 8'h00;
  localparam logic [7:0] CRC8_CHECK_123456789 = 8'hF4;

  localparam logic ACK_OK  = 1'b1;
  localparam logic ACK_NAK = 1'b0;

  // MSB-first, non-reflected, no final xor: one full byte per call.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/xspi_crc_retx_ctrl_if.sv
// rtl/xspi_crc_retx_ctrl_if.sv - payload, link and response signals of the retransmit controller
// Purpose: bundles the payload input stream (s_*), the link output stream (m_*)
//          and the link response strobe (ack_*).
// Modports: master = controller side, slave = payload source / PHY side.
interface xspi_crc_retx_ctrl_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       ack_valid;
  logic       ack_ok;

  modport master (
    input  s_valid, s_data, s_last, m_ready, ack_valid, ack_ok,
    output s_ready, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, ack_valid, ack_ok,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/crc8.sv
// rtl/crc8.sv - bytewise crc8 engine
// Purpose: accumulates a crc8 over bytes presented with enable; clear reloads INIT.
// Ports:   clk, rst (async, active-high), enable, clear, data_in[7:0], crc_out[7:0].
module crc8
  import xspi_crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_out <= INIT;
    end else if (clear) begin
      crc_out <= INIT;
    end else if (enable) begin
      crc_out <= crc8_next(crc_out, data_in, POLY);
    end
  end

endmodule

// File: rtl/xspi_crc_retx_ctrl.sv
// rtl/xspi_crc_retx_ctrl.sv - xSPI 8S transmit frame controller with crc8 and ACK/NAK retransmit
// Purpose: buffers one payload frame, streams it plus its crc8 byte to the PHY,
//          waits for ACK/NAK and retransmits on NAK or timeout up to MAX_RETRY times.
// Ports:   clk, rst (async, active-high); bus (master modport: s_* payload in,
//          m_* link out, ack_valid/ack_ok response); busy, done, fail, retry_cnt, trunc.
// Option:  CRC_ERR_INJECT_EN adds input inject_err; when set at the frame's first
//          accept, the first attempt carries a corrupted CRC byte (crc ^ 8'h01).
module xspi_crc_retx_ctrl
  import xspi_crc_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         MAX_RETRY   = 3,
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] POLY        = CRC8_POLY,
  localparam int        RW          = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  xspi_crc_retx_ctrl_if.master  bus,
`ifdef CRC_ERR_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [RW-1:0]         retry_cnt,
  output logic                  trunc
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t        state, state_nx;
  logic [7:0]    frame_buf [MAX_LEN];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
  logic [LW-1:0] len;
  logic [TW-1:0] to_cnt;
  logic [7:0]    crc_out;
  logic          crc_enable, crc_clear;
  logic          s_fire, m_fire, retry_go, crc_flip;

  // s_ready is forced low while rst is held so the IDLE state does not show it.
  assign bus.s_ready = !rst && (state == ST_IDLE || state == ST_LOAD);
  assign bus.m_valid = (state == ST_SEND) || (state == ST_SEND_CRC);
  assign s_fire      = bus.s_valid && bus.s_ready;
  assign m_fire      = bus.m_valid && bus.m_ready;
  assign busy        = (state != ST_IDLE);
  assign wr_idx      = (state == ST_IDLE) ? '0 : wr_ptr;

`ifdef CRC_ERR_INJECT_EN
  logic inj_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_q <= 1'b0;
    end else if (s_fire && state == ST_IDLE) begin
      inj_q <= inject_err;
    end
  end
  assign crc_flip = inj_q && (retry_cnt == '0);
`else
  assign crc_flip = 1'b0;
`endif

  crc8 #(.POLY(POLY), .INIT(CRC8_INIT)) u_crc8 (
    .clk     (clk),
    .rst     (rst),
    .enable  (crc_enable),
    .clear   (crc_clear),
    .data_in (bus.m_data),
    .crc_out (crc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    bus.m_data = 8'h00;
    bus.m_last = 1'b0;
    crc_enable = 1'b0;
    crc_clear  = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    retry_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_fire) state_nx = bus.s_last ? ST_PREP : ST_LOAD;
      end
      ST_LOAD: begin
        if (s_fire && (bus.s_last || wr_ptr == LAST_IDX)) state_nx = ST_PREP;
      end
      ST_PREP: begin
        crc_clear = 1'b1;
        state_nx  = ST_SEND;
      end
      ST_SEND: begin
        bus.m_data = frame_buf[rd_ptr];
        if (m_fire) begin
          crc_enable = 1'b1;
          if (LW'(rd_ptr) == len - 1'b1) state_nx = ST_SEND_CRC;
        end
      end
      ST_SEND_CRC: begin
        // The last payload enable landed on the previous edge, so crc_out is final.
        bus.m_data = crc_out ^ {7'b0, crc_flip};
        bus.m_last = 1'b1;
        if (m_fire) state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ACK arriving on the timeout cycle takes priority.
        if (bus.ack_valid && bus.ack_ok == ACK_OK) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else if (bus.ack_valid || to_cnt == TO_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_go = 1'b1;
            state_nx = ST_PREP;
          end else begin
            fail     = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      to_cnt    <= '0;
      retry_cnt <= '0;
      trunc     <= 1'b0;
    end else begin
      if (s_fire) begin
        if (state == ST_IDLE) begin
          // First accept of a new frame: per-frame status starts over.
          wr_ptr    <= AW'(1);
          retry_cnt <= '0;
          trunc     <= 1'b0;
          if (bus.s_last) len <= LW'(1);
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          if (bus.s_last || wr_ptr == LAST_IDX) begin
            len   <= LW'(wr_ptr) + 1'b1;
            trunc <= !bus.s_last;
          end
        end
      end
      if (state == ST_PREP)  rd_ptr <= '0;
      else if (crc_enable)   rd_ptr <= rd_ptr + 1'b1;
      if (state == ST_SEND_CRC && m_fire) to_cnt <= '0;
      else if (state == ST_WAIT_ACK)      to_cnt <= to_cnt + 1'b1;
      if (retry_go) retry_cnt <= retry_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire) frame_buf[wr_idx] <= bus.s_data;
  end

endmodule
